// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract: one full-adder cell with a registered carry, LSB first.
// Latency: WIDTH cycles from accepted start to the done pulse; new accept possible every WIDTH+1 cycles.
// Backpressure: start is dropped while busy=1 (no queueing); done is a single-cycle pulse.
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             last_bit;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             c;
    logic [CW-1:0]    cnt;
    // Holds the WIDTH-1 sum bits already produced; the final bit joins at completion.
    logic [WIDTH-2:0] sum_sr;

    logic             s;
    logic             cout;
    logic [WIDTH-1:0] sum_nxt;

    assign last_bit = (cnt == LAST);
    assign s        = op_a[0] ^ op_b[0] ^ c;
    assign cout     = (op_a[0] & op_b[0]) | (op_a[0] & c) | (op_b[0] & c);
    assign sum_nxt  = {s, sum_sr};

    // Next-state and accept decode; start only matters outside RUN.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                accept    = start;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; busy/done are flopped decodes of the next state so they carry no input path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == RUN);
            done  <= (state_nxt == DONE);
        end
    end

    // Operand load on accept, one serial bit per RUN cycle, parallel results at the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a     <= '0;
            op_b     <= '0;
            c        <= 1'b0;
            cnt      <= '0;
            sum_sr   <= '0;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            op_a <= a;
            op_b <= sub ? ~b : b;
            c    <= sub;
            cnt  <= '0;
        end else if (state == RUN) begin
            op_a   <= op_a >> 1;
            op_b   <= op_b >> 1;
            c      <= cout;
            sum_sr <= sum_nxt[WIDTH-1:1];
            cnt    <= cnt + CW'(1);
            if (last_bit) begin
                result   <= sum_nxt;
                carry    <= cout;
                // c here is still the carry into the MSB cell.
                overflow <= c ^ cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed checks of the bit-serial adder/subtractor at WIDTH=8.
// Latency: expects done exactly 8 cycles after the accept edge.
// Backpressure: exercises ignored start while busy and back-to-back issue in DONE.
module tb_serial_add_sub;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry;
    logic         overflow;

    int n_cmp;
    int n_bad;

    serial_add_sub #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carry    (carry),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, wait (bounded) for done, check latency and results.
    task automatic run_op(input string tag, input logic s_in, input logic [W-1:0] ia,
                          input logic [W-1:0] ib, input logic [W-1:0] er,
                          input logic ec, input logic eo);
        int  lat;
        logic busy_gap;
        start = 1'b1; sub = s_in; a = ia; b = ib;
        tick();
        start = 1'b0;
        // Scramble operands after the accept edge; they must not matter.
        a = W'($urandom); b = W'($urandom); sub = ~s_in;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        lat = 0;
        busy_gap = 1'b0;
        while (!done && lat < 40) begin
            tick();
            lat++;
            if (!done && !busy) busy_gap = 1'b1;
        end
        chk({tag, "_lat"}, lat, W);
        chk({tag, "_gap"}, {31'd0, busy_gap}, 32'd0);
        chk({tag, "_res"}, {24'd0, result}, {24'd0, er});
        chk({tag, "_cy"}, {31'd0, carry}, {31'd0, ec});
        chk({tag, "_ov"}, {31'd0, overflow}, {31'd0, eo});
        chk({tag, "_dbusy"}, {31'd0, busy}, 32'd0);
        tick();
        chk({tag, "_dclr"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int   lat;
        int   ndone;
        logic busy_gap;
        logic held;

        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_res", {24'd0, result}, 32'd0);
        chk("rst_cyov", {30'd0, carry, overflow}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;

        run_op("add3c0f", 1'b0, 8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b0);
        run_op("addff01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        run_op("add7f01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
        run_op("sub0507", 1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
        run_op("sub8001", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
        run_op("sub0707", 1'b1, 8'h07, 8'h07, 8'h00, 1'b1, 1'b0);

        // Ignored start during RUN.
        start = 1'b1; sub = 1'b0; a = 8'h10; b = 8'h20;
        tick();
        start = 1'b0;
        tick(); tick();
        start = 1'b1; sub = 1'b1; a = 8'hFF; b = 8'hFF;
        tick();
        start = 1'b0;
        ndone = 0; busy_gap = 1'b0; lat = 3;
        while (ndone == 0 && lat < 40) begin
            if (!busy) busy_gap = 1'b1;
            tick();
            lat++;
            if (done) ndone++;
        end
        chk("ign_lat", lat, W);
        chk("ign_gap", {31'd0, busy_gap}, 32'd0);
        chk("ign_res", {24'd0, result}, 32'h30);
        chk("ign_cyov", {30'd0, carry, overflow}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) ndone++;
        end
        chk("ign_once", ndone, 1);

        // Back-to-back: second start presented in the DONE cycle.
        start = 1'b1; sub = 1'b0; a = 8'h3C; b = 8'h0F;
        tick();
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        chk("b2b_lat1", lat, W);
        chk("b2b_res1", {24'd0, result}, 32'h4B);
        start = 1'b1; sub = 1'b0; a = 8'hFF; b = 8'h01;
        tick();
        start = 1'b0;
        chk("b2b_busy", {30'd0, busy, done}, 32'd2);
        lat = 1; held = 1'b1;
        while (!done && lat < 40) begin
            if (result !== 8'h4B) held = 1'b0;
            tick();
            lat++;
        end
        chk("b2b_lat2", lat, W + 1);
        chk("b2b_hold", {31'd0, held}, 32'd1);
        chk("b2b_res2", {24'd0, result}, 32'h00);
        chk("b2b_cy2", {31'd0, carry}, 32'd1);
        tick();

        // Leave nonzero results behind, then reset in the middle of an operation.
        run_op("pre_rst", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
        start = 1'b1; sub = 1'b0; a = 8'h55; b = 8'h22;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_bd", {30'd0, busy, done}, 32'd0);
        chk("mrst_res", {24'd0, result}, 32'd0);
        chk("mrst_cyov", {30'd0, carry, overflow}, 32'd0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done || busy || result != 8'h00) ndone++;
        end
        chk("mrst_quiet", ndone, 0);
        rst_n = 1'b1;
        run_op("post_rst", 1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
